regfile_wb_sched: RTL

Writeback scheduler for the 32×32 register file's single write port. Accepts register-write requests from two producers, the ALU path (A) and the load path (M), and buffers each in its own small queue. It issues the writes one per cycle in strict arrival order on `RegWre`/`WriteReg`/`WriteData`. It also flags read operands whose register still has a write pending, so the control unit can stall.

---
 rtl/regfile_wb_sched_if.sv | 35 +++
 rtl/regfile_wb_sched.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched_if.sv
// Bus bundle for the writeback scheduler: producer requests, register-file write port, hazard queries.
// Optional forwarding outputs appear when WB_FWD_EN is defined.
interface regfile_wb_sched_if;
  logic        a_valid, a_ready;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        m_valid, m_ready;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic        RegWre;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1, ReadReg2;
  logic        rd1_pend, rd2_pend, idle;
`ifdef WB_FWD_EN
  logic        rd1_fwd_valid, rd2_fwd_valid;
  logic [31:0] rd1_fwd_data, rd2_fwd_data;
`endif

  modport slave (
    input  a_valid, a_reg, a_data, m_valid, m_reg, m_data, ReadReg1, ReadReg2,
    output a_ready, m_ready, RegWre, WriteReg, WriteData, rd1_pend, rd2_pend, idle
`ifdef WB_FWD_EN
    , output rd1_fwd_valid, rd1_fwd_data, rd2_fwd_valid, rd2_fwd_data
`endif
  );

  modport master (
    output a_valid, a_reg, a_data, m_valid, m_reg, m_data, ReadReg1, ReadReg2,
    input  a_ready, m_ready, RegWre, WriteReg, WriteData, rd1_pend, rd2_pend, idle
`ifdef WB_FWD_EN
    , input rd1_fwd_valid, rd1_fwd_data, rd2_fwd_valid, rd2_fwd_data
`endif
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: two per-source FIFOs plus an arrival-order FIFO feeding the single RF write port.
// Define WB_FWD_EN to add youngest-match forwarding data alongside the pending flags.
module regfile_wb_sched #(
  parameter int DEPTH = 2
) (
  input logic             CLK,
  input logic             RST,
  regfile_wb_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]    r_a_reg  [DEPTH];
  logic [31:0]   r_a_data [DEPTH];
  logic [OW-1:0] r_a_pos  [DEPTH];
  logic [4:0]    r_m_reg  [DEPTH];
  logic [31:0]   r_m_data [DEPTH];
  logic [OW-1:0] r_m_pos  [DEPTH];
  logic [AW-1:0] r_a_wp, r_a_rp, r_m_wp, r_m_rp;
  logic [AW:0]   r_a_cnt, r_m_cnt;
  logic          r_ord [2*DEPTH];
  logic [OW-1:0] r_ord_wp, r_ord_rp;
  logic [OW:0]   r_ord_cnt;
  logic          r_wre;
  logic [4:0]    r_wreg;
  logic [31:0]   r_wdata;

  logic          w_a_push, w_m_push, w_pop, w_src, w_pop_a, w_pop_m;
  logic [OW-1:0] w_m_slot;
  logic [4:0]    w_hd_reg;
  logic [31:0]   w_hd_data;
  logic [DEPTH-1:0] w_a_vld, w_m_vld;
  logic [4:0]    w_rd [2];
  logic [1:0]    w_pend;

  assign bus.a_ready = (r_a_cnt != FULL);
  assign bus.m_ready = (r_m_cnt != FULL);
  assign w_a_push    = bus.a_valid && bus.a_ready;
  assign w_m_push    = bus.m_valid && bus.m_ready;
  // A wins the earlier order slot when both sources push on the same edge
  assign w_m_slot    = r_ord_wp + OW'(w_a_push);

  assign w_pop     = (r_ord_cnt != '0);
  assign w_src     = r_ord[r_ord_rp];
  assign w_pop_a   = w_pop && !w_src;
  assign w_pop_m   = w_pop && w_src;
  assign w_hd_reg  = w_src ? r_m_reg[r_m_rp]  : r_a_reg[r_a_rp];
  assign w_hd_data = w_src ? r_m_data[r_m_rp] : r_a_data[r_a_rp];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_a_wp <= '0; r_a_rp <= '0; r_a_cnt <= '0;
      r_m_wp <= '0; r_m_rp <= '0; r_m_cnt <= '0;
      r_ord_wp <= '0; r_ord_rp <= '0; r_ord_cnt <= '0;
      r_wre <= 1'b0; r_wreg <= '0; r_wdata <= '0;
    end else begin
      r_a_wp    <= r_a_wp + AW'(w_a_push);
      r_a_rp    <= r_a_rp + AW'(w_pop_a);
      r_a_cnt   <= r_a_cnt + (AW+1)'(w_a_push) - (AW+1)'(w_pop_a);
      r_m_wp    <= r_m_wp + AW'(w_m_push);
      r_m_rp    <= r_m_rp + AW'(w_pop_m);
      r_m_cnt   <= r_m_cnt + (AW+1)'(w_m_push) - (AW+1)'(w_pop_m);
      r_ord_wp  <= r_ord_wp + OW'(w_a_push) + OW'(w_m_push);
      r_ord_rp  <= r_ord_rp + OW'(w_pop);
      r_ord_cnt <= r_ord_cnt + (OW+1)'(w_a_push) + (OW+1)'(w_m_push) - (OW+1)'(w_pop);
      if (w_pop) begin
        r_wre   <= (w_hd_reg != 5'd0);
        r_wreg  <= w_hd_reg;
        r_wdata <= w_hd_data;
      end else begin
        r_wre   <= 1'b0;
      end
    end
  end

  // Storage is qualified by the counts, so it needs no reset
  always_ff @(posedge CLK) begin
    if (w_a_push) begin
      r_a_reg[r_a_wp]  <= bus.a_reg;
      r_a_data[r_a_wp] <= bus.a_data;
      r_a_pos[r_a_wp]  <= r_ord_wp;
      r_ord[r_ord_wp]  <= 1'b0;
    end
    if (w_m_push) begin
      r_m_reg[r_m_wp]  <= bus.m_reg;
      r_m_data[r_m_wp] <= bus.m_data;
      r_m_pos[r_m_wp]  <= w_m_slot;
      r_ord[w_m_slot]  <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_a_vld[i] = {1'b0, AW'(i) - r_a_rp} < r_a_cnt;
      w_m_vld[i] = {1'b0, AW'(i) - r_m_rp} < r_m_cnt;
    end
  end

  assign w_rd[0] = bus.ReadReg1;
  assign w_rd[1] = bus.ReadReg2;

  always_comb begin
    w_pend = '0;
    for (int p = 0; p < 2; p++) begin
      if (r_wre && r_wreg == w_rd[p]) w_pend[p] = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_a_vld[i] && r_a_reg[i] == w_rd[p]) w_pend[p] = 1'b1;
        if (w_m_vld[i] && r_m_reg[i] == w_rd[p]) w_pend[p] = 1'b1;
      end
      if (w_rd[p] == 5'd0) w_pend[p] = 1'b0;
    end
  end

  assign bus.rd1_pend  = w_pend[0];
  assign bus.rd2_pend  = w_pend[1];
  assign bus.RegWre    = r_wre;
  assign bus.WriteReg  = r_wreg;
  assign bus.WriteData = r_wdata;
  assign bus.idle      = (r_a_cnt == '0) && (r_m_cnt == '0) && !r_wre;

`ifdef WB_FWD_EN
  logic [31:0] w_fdata [2];
  // Age 0 is the output register; queued entries rank by distance from the order-FIFO head
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      logic [OW:0] best, age;
      best = '0;
      age  = '0;
      w_fdata[p] = r_wdata;
      for (int i = 0; i < DEPTH; i++) begin
        age = {1'b0, r_a_pos[i] - r_ord_rp} + (OW+1)'(1);
        if (w_a_vld[i] && r_a_reg[i] == w_rd[p] && age > best) begin
          best = age; w_fdata[p] = r_a_data[i];
        end
        age = {1'b0, r_m_pos[i] - r_ord_rp} + (OW+1)'(1);
        if (w_m_vld[i] && r_m_reg[i] == w_rd[p] && age > best) begin
          best = age; w_fdata[p] = r_m_data[i];
        end
      end
    end
  end

  assign bus.rd1_fwd_valid = w_pend[0];
  assign bus.rd2_fwd_valid = w_pend[1];
  assign bus.rd1_fwd_data  = w_fdata[0];
  assign bus.rd2_fwd_data  = w_fdata[1];
`endif
endmodule
